sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 8, number of adder results (range 1..15) accepted per accumulation run.
REQ-002 The block SHALL have parameter ACC_W, default 9, accumulator width in bits (range 8..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a run; sampled only in IDLE.
REQ-006 The block SHALL have port in_sum, input, 7, unsigned 7-bit result from the 6-bit ripple adder stage (sum plus carry-out in bit 6).
REQ-007 The block SHALL have port in_valid, input, 1, in_sum is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts in_sum this cycle.
REQ-009 The block SHALL have port acc_out, output, ACC_W, accumulated total.
REQ-010 The block SHALL have port count, output, 4, number of results accepted in the current run.
REQ-011 The block SHALL have port out_valid, output, 1, acc_out is final for the run.
REQ-012 The block SHALL have port out_ready, input, 1, downstream takes the final result.
REQ-013 The block SHALL have port ovf, output, 1, sticky flag: a sum in this run exceeded 2^ACC_W-1.
REQ-014 The block SHALL have port busy, output, 1, high in ACC and DONE.

Function
REQ-015 The FSM SHALL have states IDLE, ACC and DONE.
REQ-016 In IDLE with start=1, next state SHALL be ACC, with acc_out, count and ovf cleared to 0 on the same edge.
REQ-017 in_ready SHALL be 1 exactly when the state is ACC (a combinational decode of state only).
REQ-018 A transfer SHALL occur on an edge where in_valid=1 and in_ready=1; acc_out then gets acc_out+in_sum (zero-extended, ACC_W+1-bit internal sum) and count increments.
REQ-019 in_valid=0 in ACC SHALL leave all state unchanged (stall, no timeout).
REQ-020 The transfer that makes count equal N_SAMPLES SHALL move the FSM to DONE on the same edge; the result SHALL be visible with 1-cycle latency after the last transfer.
REQ-021 out_valid SHALL be 1 exactly in DONE; acc_out, count and ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-022 In DONE with out_ready=1, next state SHALL be IDLE; acc_out, count and ovf SHALL retain their values in IDLE until the next start.
REQ-023 start SHALL be ignored in ACC and DONE; in_valid SHALL be ignored in IDLE and DONE.
REQ-024 On any transfer whose internal sum bit ACC_W is 1, or when saturation is active and acc_out is already at maximum, ovf SHALL be set and remain set until the next start or reset.
REQ-025 in_sum=0 SHALL still count as a transfer.

Reset
REQ-026 reset=1 on an edge SHALL force state IDLE, acc_out=0, count=0 and ovf=0, and outputs in_ready=0, out_valid=0 and busy=0, overriding all other inputs including start.
REQ-027 Reset asserted mid-run (ACC or DONE) SHALL discard the run, with no partial result flagged.

Configuration
REQ-028 Macro SUM_ACCUMULATOR_SATURATE_EN SHALL select overflow handling.
REQ-029 With SUM_ACCUMULATOR_SATURATE_EN defined, an overflowing transfer SHALL clamp acc_out to 2^ACC_W-1 and set ovf.
REQ-030 Without SUM_ACCUMULATOR_SATURATE_EN, an overflowing transfer SHALL wrap acc_out modulo 2^ACC_W and set ovf.

Verification
REQ-031 Defaults: reset, then start, then 8 transfers of in_sum=10 -> 1 cycle after the last transfer, out_valid=1, acc_out=80, count=8, ovf=0.
REQ-032 Back-pressure: same run with out_ready=0 for 5 cycles -> acc_out=80 stable for all 5 cycles; out_ready=1 -> IDLE next cycle, out_valid=0.
REQ-033 Gapped input: in_valid toggled 1,0,0,1,... with in_sum values 127,1,63,0,5,5,5,5 -> acc_out=211, count=8, 12 cycles in ACC.
REQ-034 Overflow, 8 transfers of in_sum=127 (ACC_W=9) -> with the macro, acc_out=511 and ovf=1; without it, acc_out=1016 mod 512=504 and ovf=1.
REQ-035 Reset mid-run: reset after 3 transfers of 20 -> next cycle state IDLE, acc_out=0, count=0, in_ready=0; in_valid and start held high during reset have no effect.
REQ-036 Ignored inputs: start pulsed in ACC and DONE, and in_valid=1 in DONE -> no change to acc_out or count.

Source files
------------

// File: rtl/sum_accumulator.sv
// sum_accumulator: collects N_SAMPLES results from a 6-bit ripple adder stage
// into an ACC_W-bit total, then hands the total downstream with a
// valid/ready handshake.
// Optional feature macro: SUM_ACCUMULATOR_SATURATE_EN
//   defined   -> an overflowing transfer clamps the total at 2^ACC_W-1
//   undefined -> an overflowing transfer wraps modulo 2^ACC_W
// The ovf flag is sticky for the run in both builds.
module sum_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       in_sum,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [3:0]       LAST_CNT = 4'(N_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             xfer_s;
    logic             last_s;
    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             ovf_hit_s;

    // A transfer happens only while accumulating and the producer has data.
    always_comb begin
        xfer_s = (state_q == ST_ACC) && in_valid;
        last_s = xfer_s && (count_q == LAST_CNT);
        sum_s  = {1'b0, acc_q} + {{(ACC_W - 6){1'b0}}, in_sum};
    end

    // Overflow handling: clamp or wrap, and decide whether this transfer overflows.
    always_comb begin
        acc_next_s = sum_s[ACC_W-1:0];
        ovf_hit_s  = sum_s[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        if (sum_s[ACC_W] || (acc_q == ACC_MAX)) begin
            acc_next_s = ACC_MAX;
            ovf_hit_s  = 1'b1;
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
            ovf_hit_s  = 1'b0;
        end
`else
        acc_next_s = sum_s[ACC_W-1:0];
        ovf_hit_s  = sum_s[ACC_W];
`endif
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: handshake and busy flags depend on state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
            ST_ACC: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                busy      = 1'b1;
            end
            ST_DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // Datapath next state: clear on start, accumulate on transfer, else hold.
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if ((state_q == ST_IDLE) && start) begin
            acc_d   = {ACC_W{1'b0}};
            count_d = 4'd0;
            ovf_d   = 1'b0;
        end else if (xfer_s) begin
            acc_d   = acc_next_s;
            count_d = count_q + 4'd1;
            ovf_d   = ovf_q | ovf_hit_s;
        end else begin
            acc_d   = acc_q;
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    // Datapath registers; reset discards any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= {ACC_W{1'b0}};
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign count   = count_q;
    assign ovf     = ovf_q;

endmodule
